// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the successive-approximation search controller
package sar_pkg;

    localparam int SAR_N = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        VERIFY = 2'd2
    } sar_state_t;

    // Comparator verdict after priority resolution; NONE means no flag was raised
    typedef enum logic [1:0] {
        RES_LO   = 2'd0,
        RES_GR   = 2'd1,
        RES_EQ   = 2'd2,
        RES_NONE = 2'd3
    } sar_res_t;

    // eq wins over gr, gr wins over lo
    function automatic sar_res_t sar_decode(input logic eq, input logic gr, input logic lo);
        if (eq)
            return RES_EQ;
        else if (gr)
            return RES_GR;
        else if (lo)
            return RES_LO;
        else
            return RES_NONE;
    endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// rtl/sar_search_ctrl_if.sv - probe/result link between the search controller and a magnitude comparator
interface sar_search_ctrl_if
    import sar_pkg::*;
#(
    parameter int N = SAR_N
);

    logic [N-1:0] probe;
    logic         cmp_gr;
    logic         cmp_lo;
    logic         cmp_eq;

    modport master (
        output probe,
        input  cmp_gr,
        input  cmp_lo,
        input  cmp_eq
    );

    modport slave (
        input  probe,
        output cmp_gr,
        output cmp_lo,
        output cmp_eq
    );

endinterface

// File: rtl/sar_search_ctrl.sv
// rtl/sar_search_ctrl.sv - MSB-first successive-approximation search with a final verify probe
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int N = SAR_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    sar_search_ctrl_if.master     cmp,
    output logic                  busy,
    output logic                  done,
    output logic [N-1:0]          result,
    output logic                  found
);

    localparam logic [N-1:0] MASK_MSB = {1'b1, {(N-1){1'b0}}};

    sar_state_t   state_q;
    sar_state_t   state_d;
    logic [N-1:0] acc_q;
    logic [N-1:0] mask_q;
    logic [N-1:0] result_q;
    logic         found_q;
    logic         done_q;
    logic [N-1:0] probe_w;
    sar_res_t     res_w;

    // Probe is the bits kept so far plus the bit under trial; in IDLE and VERIFY mask is zero
    assign probe_w = acc_q | mask_q;
    assign res_w   = sar_decode(cmp.cmp_eq, cmp.cmp_gr, cmp.cmp_lo);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: start only matters in IDLE; SEARCH leaves early on eq or after the LSB trial
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = SEARCH;
            end
            SEARCH: begin
                if (res_w == RES_EQ)
                    state_d = IDLE;
                else if (mask_q[0])
                    state_d = VERIFY;
            end
            VERIFY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: trial-bit shift register, accumulator and the completion registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mask_q   <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        mask_q   <= MASK_MSB;
                        result_q <= '0;
                        found_q  <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (res_w == RES_EQ) begin
                        // Exact hit: capture it and drop back so IDLE probes zero again
                        result_q <= probe_w;
                        found_q  <= 1'b1;
                        done_q   <= 1'b1;
                        acc_q    <= '0;
                        mask_q   <= '0;
                    end else begin
                        // A missing verdict is treated as lo, so the trial bit is dropped
                        if (res_w == RES_GR)
                            acc_q <= acc_q | mask_q;
                        mask_q <= mask_q >> 1;
                    end
                end
                VERIFY: begin
                    result_q <= acc_q;
                    found_q  <= cmp.cmp_eq;
                    done_q   <= 1'b1;
                    acc_q    <= '0;
                    mask_q   <= '0;
                end
                default: begin
                    acc_q  <= '0;
                    mask_q <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from registers only
    always_comb begin
        busy      = (state_q == SEARCH) || (state_q == VERIFY);
        done      = done_q;
        result    = result_q;
        found     = found_q;
        cmp.probe = probe_w;
    end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb/tb_sar_search_ctrl.sv - directed vector bench for sar_search_ctrl at N=8
module tb_sar_search_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       found;
    logic [7:0] target;
    int         mode;
    int         checks;
    int         errors;

    sar_search_ctrl_if #(.N(8)) cif ();

    sar_search_ctrl #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp    (cif),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural comparator: 0 = honest, 1 = stuck gr, 2 = no flags at all
    always_comb begin
        cif.cmp_gr = 1'b0;
        cif.cmp_lo = 1'b0;
        cif.cmp_eq = 1'b0;
        if (mode == 0) begin
            cif.cmp_gr = target > cif.probe;
            cif.cmp_lo = target < cif.probe;
            cif.cmp_eq = target == cif.probe;
        end else if (mode == 1) begin
            cif.cmp_gr = 1'b1;
        end
    end

    typedef struct {
        logic [7:0]      target;
        int              mode;
        int              n_probes;
        logic [0:8][7:0] probes;
        logic [7:0]      exp_result;
        logic            exp_found;
        int              exp_done;
    } vec_t;

    vec_t vecs[7];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then follow the search cycle by cycle until done
    task automatic run_vec(input int idx);
        vec_t v;
        int   busy_n;
        bit   seen;
        v      = vecs[idx];
        target = v.target;
        mode   = v.mode;
        busy_n = 0;
        seen   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            if (cyc <= v.n_probes)
                check_val($sformatf("v%0d probe c%0d", idx, cyc), 32'(cif.probe), 32'(v.probes[cyc-1]));
            if (done) begin
                seen = 1;
                check_val($sformatf("v%0d done_cycle", idx), cyc, v.exp_done);
                check_val($sformatf("v%0d result", idx), 32'(result), 32'(v.exp_result));
                check_val($sformatf("v%0d found", idx), 32'(found), 32'(v.exp_found));
                check_val($sformatf("v%0d busy_cycles", idx), busy_n, v.exp_done - 1);
                check_val($sformatf("v%0d busy_at_done", idx), 32'(busy), 0);
            end else begin
                if (busy)
                    busy_n++;
                @(posedge clk);
                #1;
            end
        end
        if (!seen)
            check_val($sformatf("v%0d done_timeout", idx), 0, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        target = 8'h00;
        mode   = 0;

        vecs[0] = '{8'hA5, 0, 8, {8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5, 8'h00}, 8'hA5, 1'b1, 9};
        vecs[1] = '{8'h80, 0, 1, {8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h80, 1'b1, 2};
        vecs[2] = '{8'h00, 0, 9, {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00}, 8'h00, 1'b1, 10};
        vecs[3] = '{8'h00, 1, 9, {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF}, 8'hFF, 1'b0, 10};
        vecs[4] = '{8'h00, 2, 9, {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00}, 8'h00, 1'b0, 10};
        vecs[5] = '{8'h3C, 0, 6, {8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h00, 8'h00, 8'h00}, 8'h3C, 1'b1, 7};
        vecs[6] = '{8'hFF, 0, 8, {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00}, 8'hFF, 1'b1, 9};

        repeat (2) @(posedge clk);
        #1;
        check_val("reset probe", 32'(cif.probe), 0);
        check_val("reset busy", 32'(busy), 0);
        check_val("reset done", 32'(done), 0);
        check_val("reset found", 32'(found), 0);
        check_val("reset result", 32'(result), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_vec(i);

        // Reset in the middle of a search: everything back to idle, no done pulse
        target = 8'hA5;
        mode   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_val("rst mid busy", 32'(busy), 1);
        check_val("rst mid probe", 32'(cif.probe), 32'h0000_00B0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst after busy", 32'(busy), 0);
        check_val("rst after probe", 32'(cif.probe), 0);
        check_val("rst after result", 32'(result), 0);
        check_val("rst after found", 32'(found), 0);
        check_val("rst after done", 32'(done), 0);
        @(posedge clk);
        #1;
        check_val("rst later done", 32'(done), 0);
        check_val("rst later busy", 32'(busy), 0);
        run_vec(0);

        // Start re-pulsed mid-search and held: ignored while busy, accepted in the done cycle
        begin
            bit seen;
            seen   = 0;
            target = 8'hA5;
            mode   = 0;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
                if (cyc == 3)
                    start = 1'b1;
                if (done) begin
                    seen = 1;
                    check_val("hold done_cycle", cyc, 9);
                    check_val("hold result", 32'(result), 32'h0000_00A5);
                    check_val("hold found", 32'(found), 1);
                end else begin
                    check_val($sformatf("hold busy c%0d", cyc), 32'(busy), 1);
                    @(posedge clk);
                    #1;
                end
            end
            if (!seen)
                check_val("hold done_timeout", 0, 1);
            @(posedge clk);
            #1;
            start = 1'b0;
            check_val("hold restart busy", 32'(busy), 1);
            check_val("hold restart probe", 32'(cif.probe), 32'h0000_0080);
            check_val("hold restart result", 32'(result), 0);
            check_val("hold restart found", 32'(found), 0);
            seen = 0;
            for (int cyc = 10; cyc <= 30 && !seen; cyc++) begin
                if (done) begin
                    seen = 1;
                    check_val("hold2 done_cycle", cyc, 18);
                    check_val("hold2 result", 32'(result), 32'h0000_00A5);
                    check_val("hold2 found", 32'(found), 1);
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!seen)
                check_val("hold2 done_timeout", 0, 1);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
